styler_sequencer: RTL and testbench
===================================

# styler_sequencer

Controller that drives the glyph styler datapath one character cell at a time. It accepts a cell (glyph code, 25-bit attribute word, cursor flag) and walks output scanlines 0–15. For each scanline it asks the styler which source row to use, fetches that row from font memory, captures the styled 16-bit row, and streams it downstream over a valid/ready handshake. It also owns the frame counter that generates the faint, blink and cursor phase signals.

## Interface
Parameters:
- FONT_AW, 12, font address width; font_addr = {glyph[7:0], src_row[3:0]}. Fixed at 12 in this revision.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- abort  in  1  synchronous; drops the current cell.
- cell_valid  in  1  cell offered.
- cell_ready  out  1  high only in IDLE.
- cell_glyph  in  8  glyph code.
- cell_attr  in  25  attribute word, styler bit order.
- cell_cursor  in  1  cursor is on this cell.
- sty_scanline  out  4  scanline presented to styler.
- sty_bitmap  out  16  source row presented to styler.
- sty_attr  out  25  latched attribute word.
- sty_cursor_en  out  1  latched cell_cursor.
- sty_faint_phase, sty_blink_phase, sty_cursor_phase  out  1 each  latched phases.
- sty_src_row  in  4  styler's mapped source scanline (combinational from sty_scanline/sty_attr).
- sty_row  in  16  styler's styled row (combinational).
- font_req  out  1  font read request, held until ack.
- font_addr  out  12  font read address, stable while font_req.
- font_ack  in  1  font_data valid this cycle.
- font_data  in  16  font row.
- row_valid  out  1  styled row available.
- row_ready  in  1  downstream accepts.
- row_data  out  16  styled row.
- row_index  out  4  output scanline of row_data.
- row_last  out  1  row_index == 15.

## Operation
- FSM states: IDLE, MAP, FETCH, STYLE, OUT.
- IDLE: cell_ready=1. On cell_valid, latch the following and go to MAP:
  - glyph, attr and cursor;
  - phases from frame_cnt;
  - scanline counter = 0.
- MAP (1 cycle): drive sty_scanline = scanline counter. Capture sty_src_row into src_row, then go to FETCH.
- FETCH: font_req=1 and font_addr={glyph, src_row}. On font_ack, capture font_data into sty_bitmap, drop font_req and go to STYLE.
- STYLE (1 cycle): capture sty_row into row_data, and scanline counter into row_index. Go to OUT.
- OUT: row_valid=1. On row_ready:
  - if row_index==15, go to IDLE;
  - else increment the scanline counter and go to MAP.
- frame_cnt: 6 bits, increments on every frame_tick in every state, wraps 63→0.
  - faint = frame_cnt[0], blink = frame_cnt[5], cursor = frame_cnt[4].
  - Phases are latched only at cell accept, so one cell never mixes phases.
- abort (any non-IDLE state): next state IDLE.
  - font_req and row_valid deassert next cycle; an in-flight font_ack is ignored.
  - abort in IDLE is a no-op.
  - abort has priority over cell_valid and row_ready in the same cycle.
- The scanline counter wraps only via the row_index==15 exit; it never rolls over silently.

## Timing
- Reset (async assert): state IDLE, frame_cnt=0, all latches 0. Outputs:
  - font_req=0, row_valid=0, row_data=0, row_index=0, sty_*=0;
  - cell_ready=1 once rst deasserts.
- Cell accept: cell_valid&cell_ready at edge N → MAP during cycle N+1.
- Per row, with font_ack in the first FETCH cycle and row_ready held: MAP 1 + FETCH 1 + STYLE 1 + OUT 1 = 4 cycles.
  - Minimum 64 cycles per cell.
  - Next cell is accepted no earlier than the cycle after the last OUT handshake.
- font_req and font_addr are registered and remain stable until font_ack.
- row_valid, row_data and row_index are registered. They hold steady while row_valid&~row_ready (no drop, no change).
- frame_tick in the same cycle as cell accept: the pre-increment frame_cnt is latched.

## Test plan
- Reset then idle: assert rst mid-FETCH → font_req=0, row_valid=0 and cell_ready=1 immediately. frame_cnt reads 0 via latched phases on the next cell.
- Single cell, glyph 0x41, attr 0, ideal memory (ack same cycle, row_ready=1):
  - model styler as src_row=scanline, row=bitmap;
  - 16 rows arrive with font_addr 0x410..0x41F;
  - row_index 0..15, row_last only on 15;
  - total 64 cycles from accept to last handshake.
- Backpressure: row_ready low for 5 cycles on row 7 → row_valid, row_data and row_index held for 5 cycles; no font_req issued meanwhile; no row lost or duplicated.
- Slow font: font_ack 3 cycles late on every row → font_addr stable throughout; 112 cycles per cell.
- Phases: 48 frame_ticks then accept a cell → faint=0, blink=1, cursor=1. After 16 more ticks (wrap to 0), next cell → all phases 0.
- Abort: abort on row 3 OUT together with row_ready → no row 4 fetched; IDLE next cycle. A new cell accepted 2 cycles later starts at row_index 0.

Source files
------------

// File: rtl/styler_sequencer.sv
// styler_sequencer: walks one character cell through scanlines 0..15,
// mapping each scanline through the styler, fetching the source font row,
// capturing the styled row and streaming it out over valid/ready.
// Also owns the 6-bit frame counter that feeds the faint/blink/cursor phases.
module styler_sequencer #(
    parameter int FONT_AW = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               abort,
    input  logic               cell_valid,
    output logic               cell_ready,
    input  logic [7:0]         cell_glyph,
    input  logic [24:0]        cell_attr,
    input  logic               cell_cursor,
    output logic [3:0]         sty_scanline,
    output logic [15:0]        sty_bitmap,
    output logic [24:0]        sty_attr,
    output logic               sty_cursor_en,
    output logic               sty_faint_phase,
    output logic               sty_blink_phase,
    output logic               sty_cursor_phase,
    input  logic [3:0]         sty_src_row,
    input  logic [15:0]        sty_row,
    output logic               font_req,
    output logic [FONT_AW-1:0] font_addr,
    input  logic               font_ack,
    input  logic [15:0]        font_data,
    output logic               row_valid,
    input  logic               row_ready,
    output logic [15:0]        row_data,
    output logic [3:0]         row_index,
    output logic               row_last
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAP   = 3'd1,
        FETCH = 3'd2,
        STYLE = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t              state_q;
    logic [5:0]          frame_cnt_q;
    logic [5:0]          frame_cnt_d;
    logic [7:0]          glyph_q;
    logic [24:0]         attr_q;
    logic                cursor_en_q;
    logic                faint_q;
    logic                blink_q;
    logic                cursor_ph_q;
    logic [3:0]          scan_q;
    logic [15:0]         bitmap_q;
    logic                font_req_q;
    logic [FONT_AW-1:0]  font_addr_q;
    logic                row_valid_q;
    logic [15:0]         row_data_q;
    logic [3:0]          row_index_q;
    logic                row_last_q;

    // Frame counter advances on every frame pulse regardless of FSM state.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_tick) begin
            frame_cnt_d = frame_cnt_q + 6'd1;
        end
    end

    // Frame counter register; wraps naturally from 63 to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 6'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Cell sequencing FSM with all handshake and styler-facing outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            glyph_q     <= 8'd0;
            attr_q      <= 25'd0;
            cursor_en_q <= 1'b0;
            faint_q     <= 1'b0;
            blink_q     <= 1'b0;
            cursor_ph_q <= 1'b0;
            scan_q      <= 4'd0;
            bitmap_q    <= 16'd0;
            font_req_q  <= 1'b0;
            font_addr_q <= '0;
            row_valid_q <= 1'b0;
            row_data_q  <= 16'd0;
            row_index_q <= 4'd0;
            row_last_q  <= 1'b0;
        end else if (abort && (state_q != IDLE)) begin
            // Dropping the cell: any pending ack or downstream accept is ignored.
            state_q     <= IDLE;
            font_req_q  <= 1'b0;
            row_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cell_valid) begin
                        glyph_q     <= cell_glyph;
                        attr_q      <= cell_attr;
                        cursor_en_q <= cell_cursor;
                        faint_q     <= frame_cnt_q[0];
                        blink_q     <= frame_cnt_q[5];
                        cursor_ph_q <= frame_cnt_q[4];
                        scan_q      <= 4'd0;
                        state_q     <= MAP;
                    end
                end
                MAP: begin
                    font_addr_q <= {glyph_q, sty_src_row};
                    font_req_q  <= 1'b1;
                    state_q     <= FETCH;
                end
                FETCH: begin
                    if (font_ack) begin
                        bitmap_q   <= font_data;
                        font_req_q <= 1'b0;
                        state_q    <= STYLE;
                    end
                end
                STYLE: begin
                    row_data_q  <= sty_row;
                    row_index_q <= scan_q;
                    row_last_q  <= (scan_q == 4'd15);
                    row_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (row_ready) begin
                        row_valid_q <= 1'b0;
                        if (row_index_q == 4'd15) begin
                            state_q <= IDLE;
                        end else begin
                            scan_q  <= scan_q + 4'd1;
                            state_q <= MAP;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cell_ready       = (state_q == IDLE);
    assign sty_scanline     = scan_q;
    assign sty_bitmap       = bitmap_q;
    assign sty_attr         = attr_q;
    assign sty_cursor_en    = cursor_en_q;
    assign sty_faint_phase  = faint_q;
    assign sty_blink_phase  = blink_q;
    assign sty_cursor_phase = cursor_ph_q;
    assign font_req         = font_req_q;
    assign font_addr        = font_addr_q;
    assign row_valid        = row_valid_q;
    assign row_data         = row_data_q;
    assign row_index        = row_index_q;
    assign row_last         = row_last_q;

endmodule

// File: tb/tb_styler_sequencer.sv
// Scoreboard bench for styler_sequencer: a styler and font memory are
// modelled around the DUT, each accepted cell pushes its 16 expected rows
// and font addresses, and a monitor pops and compares on every handshake.
module tb_styler_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        abort;
    logic        cell_valid;
    logic        cell_ready;
    logic [7:0]  cell_glyph;
    logic [24:0] cell_attr;
    logic        cell_cursor;
    logic [3:0]  sty_scanline;
    logic [15:0] sty_bitmap;
    logic [24:0] sty_attr;
    logic        sty_cursor_en;
    logic        sty_faint_phase;
    logic        sty_blink_phase;
    logic        sty_cursor_phase;
    logic [3:0]  sty_src_row;
    logic [15:0] sty_row;
    logic        font_req;
    logic [11:0] font_addr;
    logic        font_ack;
    logic [15:0] font_data;
    logic        row_valid;
    logic        row_ready;
    logic [15:0] row_data;
    logic [3:0]  row_index;
    logic        row_last;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  idx;
        logic        last;
        logic [24:0] attr;
        logic [3:0]  flags;
    } row_exp_t;

    row_exp_t    rowQ[$];
    logic [11:0] addrQ[$];

    int vectors = 0;
    int miscompares = 0;
    int cycleCount = 0;
    int tickCount = 0;
    int acceptCycle = 0;
    int lastCellCycles = 0;
    int fontDelayMode = 0;
    int rdyMode = 0;
    int readyForce = 1;
    int tickPending = 0;
    bit tickEn = 1'b0;

    styler_sequencer #(.FONT_AW(12)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .abort(abort),
        .cell_valid(cell_valid), .cell_ready(cell_ready),
        .cell_glyph(cell_glyph), .cell_attr(cell_attr), .cell_cursor(cell_cursor),
        .sty_scanline(sty_scanline), .sty_bitmap(sty_bitmap), .sty_attr(sty_attr),
        .sty_cursor_en(sty_cursor_en), .sty_faint_phase(sty_faint_phase),
        .sty_blink_phase(sty_blink_phase), .sty_cursor_phase(sty_cursor_phase),
        .sty_src_row(sty_src_row), .sty_row(sty_row),
        .font_req(font_req), .font_addr(font_addr), .font_ack(font_ack), .font_data(font_data),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_index(row_index), .row_last(row_last)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Cycle counter used for latency measurements.
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Styler stand-in: the attribute word perturbs both the row mapping and the pixels.
    assign sty_src_row = sty_scanline ^ sty_attr[3:0];
    assign sty_row     = sty_bitmap ^ sty_attr[24:9];

    function automatic logic [15:0] fontRow(input logic [11:0] a);
        logic [31:0] x;
        x = {20'd0, a} * 32'h9E3779B1;
        return x[31:16] ^ 16'hA5C3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Font memory: acks each request after a chosen delay and checks address stability.
    initial begin
        int waitCnt;
        bit seen;
        logic [11:0] reqAddr;
        seen = 1'b0;
        waitCnt = 0;
        reqAddr = 12'd0;
        font_ack = 1'b0;
        font_data = 16'd0;
        forever begin
            @(negedge clk);
            font_ack = 1'b0;
            font_data = 16'($urandom);
            if (font_req === 1'b1 && rst === 1'b0) begin
                if (!seen) begin
                    seen = 1'b1;
                    waitCnt = (fontDelayMode < 0) ? int'($urandom_range(0, 3)) : fontDelayMode;
                    reqAddr = font_addr;
                end else begin
                    checkOutput("font_addr_stable", 32'(font_addr), 32'(reqAddr));
                end
                if (waitCnt == 0) begin
                    font_ack = 1'b1;
                    font_data = fontRow(font_addr);
                    seen = 1'b0;
                end else begin
                    waitCnt--;
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Background drivers for downstream ready and frame pulses.
    initial begin
        row_ready = 1'b1;
        frame_tick = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rdyMode == 0) row_ready = 1'b1;
            else if (rdyMode == 1) row_ready = ($urandom_range(0, 3) != 0);
            else row_ready = (readyForce != 0);
            if (tickPending > 0) begin
                frame_tick = 1'b1;
                tickPending--;
            end else if (tickEn) begin
                frame_tick = ($urandom_range(0, 7) == 0);
            end else begin
                frame_tick = 1'b0;
            end
        end
    end

    // Monitor: builds expectations on cell accept and checks every handshake.
    initial begin
        bit prevHold;
        logic [15:0] prevData;
        logic [3:0] prevIdx;
        row_exp_t it;
        logic [3:0] src;
        logic [11:0] a;
        prevHold = 1'b0;
        prevData = 16'd0;
        prevIdx = 4'd0;
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b0) begin
                rowQ.delete();
                addrQ.delete();
                tickCount = 0;
                prevHold = 1'b0;
                continue;
            end
            if (abort && !cell_ready) begin
                rowQ.delete();
                addrQ.delete();
                prevHold = 1'b0;
            end else begin
                if (prevHold) begin
                    checkOutput("hold_valid", 32'(row_valid), 32'd1);
                    checkOutput("hold_data", 32'(row_data), 32'(prevData));
                    checkOutput("hold_index", 32'(row_index), 32'(prevIdx));
                end
                if (row_valid) checkOutput("no_fetch_while_out", 32'(font_req), 32'd0);
                if (row_valid && row_ready) begin
                    checkOutput("row_expected", 32'(rowQ.size() != 0), 32'd1);
                    if (rowQ.size() != 0) begin
                        it = rowQ.pop_front();
                        checkOutput("row_data", 32'(row_data), 32'(it.data));
                        checkOutput("row_index", 32'(row_index), 32'(it.idx));
                        checkOutput("row_last", 32'(row_last), 32'(it.last));
                        checkOutput("sty_attr", 32'(sty_attr), 32'(it.attr));
                        checkOutput("sty_flags",
                            32'({sty_cursor_en, sty_faint_phase, sty_blink_phase, sty_cursor_phase}),
                            32'(it.flags));
                        if (it.last) lastCellCycles = cycleCount - acceptCycle;
                    end
                end
                if (font_req && font_ack) begin
                    checkOutput("fetch_expected", 32'(addrQ.size() != 0), 32'd1);
                    if (addrQ.size() != 0) begin
                        a = addrQ.pop_front();
                        checkOutput("font_addr", 32'(font_addr), 32'(a));
                    end
                end
                prevHold = row_valid && !row_ready;
                prevData = row_data;
                prevIdx = row_index;
                if (cell_valid && cell_ready) begin
                    acceptCycle = cycleCount;
                    for (int s = 0; s < 16; s++) begin
                        src = s[3:0] ^ cell_attr[3:0];
                        a = {cell_glyph, src};
                        it.data = fontRow(a) ^ cell_attr[24:9];
                        it.idx = s[3:0];
                        it.last = (s == 15);
                        it.attr = cell_attr;
                        it.flags = {cell_cursor, (tickCount % 2) == 1,
                                    ((tickCount / 32) % 2) == 1, ((tickCount / 16) % 2) == 1};
                        rowQ.push_back(it);
                        addrQ.push_back(a);
                    end
                end
            end
            if (frame_tick) tickCount = (tickCount + 1) % 64;
        end
    end

    task automatic applyStimulus(input logic [7:0] g, input logic [24:0] at, input logic cur);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!cell_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("cell_ready_wait", 32'(cell_ready), 32'd1);
        cell_valid = 1'b1;
        cell_glyph = g;
        cell_attr = at;
        cell_cursor = cur;
        @(negedge clk);
        cell_valid = 1'b0;
        cell_glyph = 8'($urandom);
        cell_attr = 25'($urandom);
        cell_cursor = 1'($urandom);
    endtask

    task automatic waitDone();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(rowQ.size() == 0 && cell_ready) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain", 32'(rowQ.size()), 32'd0);
    endtask

    task automatic waitRow(input logic [3:0] idx);
        int guard;
        guard = 0;
        while (!(row_valid && row_index == idx) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("wait_row", 32'(row_valid), 32'd1);
    endtask

    task automatic waitFontReq();
        int guard;
        guard = 0;
        while (!font_req && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("wait_font_req", 32'(font_req), 32'd1);
    endtask

    task automatic waitTicks();
        int guard;
        guard = 0;
        while (tickPending > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence.
    initial begin
        rst = 1'b1;
        abort = 1'b0;
        cell_valid = 1'b0;
        cell_glyph = 8'd0;
        cell_attr = 25'd0;
        cell_cursor = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_font_req", 32'(font_req), 32'd0);
        checkOutput("rst_row_valid", 32'(row_valid), 32'd0);
        checkOutput("rst_row_data", 32'(row_data), 32'd0);
        checkOutput("rst_row_index", 32'(row_index), 32'd0);
        checkOutput("rst_sty_attr", 32'(sty_attr), 32'd0);
        checkOutput("rst_sty_misc",
            32'({sty_scanline, sty_bitmap, sty_cursor_en, sty_faint_phase, sty_blink_phase, sty_cursor_phase}),
            32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_cell_ready", 32'(cell_ready), 32'd1);

        // Ideal memory, glyph 0x41, attr 0.
        fontDelayMode = 0;
        rdyMode = 0;
        applyStimulus(8'h41, 25'd0, 1'b0);
        waitDone();
        checkOutput("cycles_ideal", 32'(lastCellCycles), 32'd64);

        // Backpressure on row 7 for 5 cycles.
        rdyMode = 2;
        readyForce = 1;
        applyStimulus(8'hC3, 25'h1A5F0E2, 1'b1);
        waitRow(4'd7);
        readyForce = 0;
        repeat (5) @(negedge clk);
        readyForce = 1;
        waitDone();
        checkOutput("cycles_backpressure", 32'(lastCellCycles), 32'd69);

        // Slow font memory, ack three cycles late.
        rdyMode = 0;
        fontDelayMode = 3;
        applyStimulus(8'h7E, 25'h0F0F0F5, 1'b1);
        waitDone();
        checkOutput("cycles_slow_font", 32'(lastCellCycles), 32'd112);

        // Reset in the middle of a fetch.
        applyStimulus(8'h22, 25'h1234567, 1'b0);
        waitFontReq();
        rst = 1'b1;
        #1;
        checkOutput("midrst_font_req", 32'(font_req), 32'd0);
        checkOutput("midrst_row_valid", 32'(row_valid), 32'd0);
        checkOutput("midrst_cell_ready", 32'(cell_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        fontDelayMode = 0;

        // Phase latching: 48 ticks, then 16 more to wrap.
        tickPending = 48;
        waitTicks();
        applyStimulus(8'h10, 25'h0000100, 1'b1);
        checkOutput("phases_48",
            32'({sty_faint_phase, sty_blink_phase, sty_cursor_phase}), 32'b011);
        waitDone();
        tickPending = 16;
        waitTicks();
        applyStimulus(8'h11, 25'h0000200, 1'b0);
        checkOutput("phases_wrap",
            32'({sty_faint_phase, sty_blink_phase, sty_cursor_phase}), 32'b000);
        waitDone();

        // Abort on row 3 OUT together with row_ready.
        rdyMode = 2;
        readyForce = 1;
        applyStimulus(8'h55, 25'h0ABCDEF, 1'b0);
        waitRow(4'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput("abort_row_valid", 32'(row_valid), 32'd0);
        checkOutput("abort_font_req", 32'(font_req), 32'd0);
        checkOutput("abort_cell_ready", 32'(cell_ready), 32'd1);
        applyStimulus(8'h56, 25'h1357924, 1'b1);
        waitDone();

        // Abort in FETCH while the memory acks in the same cycle.
        applyStimulus(8'h9A, 25'h0246801, 1'b0);
        waitFontReq();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        checkOutput("abort_fetch_font_req", 32'(font_req), 32'd0);
        checkOutput("abort_fetch_cell_ready", 32'(cell_ready), 32'd1);

        // Abort while idle does nothing.
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_idle_ready", 32'(cell_ready), 32'd1);
        applyStimulus(8'h9B, 25'h1FFFFFF, 1'b1);
        waitDone();

        // Randomized cells with random memory latency, backpressure and frame ticks.
        fontDelayMode = -1;
        rdyMode = 1;
        tickEn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            applyStimulus(8'($urandom), 25'($urandom), 1'($urandom));
            waitDone();
        end
        tickEn = 1'b0;
        rdyMode = 0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
